lsu_access_sequencer: RTL

- Initiator side of the CPU data-memory interface: accepts one load/store request from the MEM stage and drives word-granular, byte-strobed accesses to the data memory/MMIO fabric.
- Splits misaligned half/word accesses into two word beats and merges the read beats.
- Performs load sign/zero extension and returns a single response per request.
- Sits between the pipeline MEM stage and the data RAM.

---
 rtl/lsu_access_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lsu_access_sequencer.sv
// rtl/lsu_access_sequencer.sv - load/store sequencer: word-granular strobed beats, misaligned split and load merge
module lsu_access_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] split_count
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t           state, state_next;
  logic             we_q, err_q, split_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q, wdata_q, lo_q, hi_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_illegal, in_split, in_err;
  logic [1:0]       off;
  logic [3:0]       mask;
  logic [31:0]      word0;
  logic [31:0]      ld_word;
  logic [31:0]      ld_ext;

  // Decode of the incoming request, used only on the accepting edge
  always_comb begin
    in_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: in_illegal = 1'b0;
      3'b100, 3'b101:         in_illegal = req_we;
      default:                in_illegal = 1'b1;
    endcase
    in_split = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    in_err   = in_illegal || (in_split && (ALLOW_MISALIGNED == 1'b0));
  end

  always_comb begin
    off   = addr_q[1:0];
    word0 = {addr_q[31:2], 2'b00};
    case (f3_q[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    // hi_q is zero for unsplit accesses, so one shift serves both cases
    ld_word = 32'({hi_q, lo_q} >> {off, 3'b000});
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'd0, ld_word[7:0]};
      3'b101:  ld_ext = {16'd0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wstrb  = 4'd0;
    mem_wdata  = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = in_err ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = word0;
        if (we_q) begin
          mem_wstrb = 4'({4'b0000, mask} << off);
          mem_wdata = wdata_q << {off, 3'b000};
        end
        if (mem_ready) state_next = split_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = word0 + 32'd4;
        if (we_q) begin
          mem_wstrb = mask >> (3'd4 - {1'b0, off});
          mem_wdata = wdata_q >> {(3'd4 - {1'b0, off}), 3'b000};
        end
        if (mem_ready) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) resp_rdata = ld_ext;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= in_err;
        split_q <= in_split && !in_illegal;
        lo_q    <= 32'd0;
        hi_q    <= 32'd0;
      end
      if (state == BEAT0 && mem_ready) lo_q <= mem_rdata;
      if (state == BEAT1 && mem_ready) hi_q <= mem_rdata;
      if (state == RESP && split_q && !err_q && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign split_count = cnt_q;

endmodule
